dbc_host_enumerator: RTL

//  Debug-host-side enumeration sequencer for the DbC link; drives the attached DbC port through
//  bus reset, SET_ADDRESS, GET_DESCRIPTOR and SET_CONFIGURATION, plus deconfigure and error recovery.

---
 rtl/dbc_host_enumerator.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/dbc_host_enumerator.sv
// dbc_host_enumerator
// Debug-host-side enumeration sequencer for the DbC link. Walks the attached
// port through bus reset, recovery, SET_ADDRESS, GET_DESCRIPTOR and
// SET_CONFIGURATION, supports deconfigure/reconfigure, and retries failed
// enumerations from bus reset before latching an error state.
// Optional feature: define DBC_HOST_ENUM_CNT_EN to add the enum_count output
// (saturating count of completed configurations, cleared only by reset).
module dbc_host_enumerator #(
  parameter int unsigned RESET_CYCLES    = 50,
  parameter int unsigned RECOVERY_CYCLES = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 200,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter logic [6:0]  DEV_ADDR        = 7'd1,
  parameter logic [7:0]  CONFIG_VAL      = 8'd1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       connect,
  input  logic       host_reset,
  input  logic       deconfigure,
  output logic       port_reset,
  output logic       req_valid,
  output logic [1:0] req_type,
  output logic [7:0] req_data,
  input  logic       req_ready,
  input  logic       rsp_valid,
  input  logic       rsp_ok,
  output logic [3:0] state,
  output logic [6:0] dev_addr,
  output logic       configured,
  output logic       enum_error,
  output logic [1:0] retry_cnt
`ifdef DBC_HOST_ENUM_CNT_EN
  ,
  output logic [7:0] enum_count
`endif
);

  typedef enum logic [3:0] {
    H_OFF          = 4'd0,
    H_DISCONNECTED = 4'd1,
    H_RESET        = 4'd2,
    H_RECOVERY     = 4'd3,
    H_SET_ADDR     = 4'd4,
    H_GET_DESC     = 4'd5,
    H_SET_CONFIG   = 4'd6,
    H_CONFIGURED   = 4'd7,
    H_DECONFIG     = 4'd8,
    H_ADDRESSED    = 4'd9,
    H_ERROR        = 4'd10
  } host_state_t;

  // Last timer value of each timed phase; the timer counts from 0 on entry.
  localparam logic [15:0] RESET_LAST    = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] RECOVERY_LAST = 16'(RECOVERY_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  RETRY_LIMIT   = 2'(MAX_RETRIES);

  // Request code carried to the transfer engine in each request state.
  localparam logic [1:0] REQ_SET_ADDRESS = 2'b00;
  localparam logic [1:0] REQ_GET_DESC    = 2'b01;
  localparam logic [1:0] REQ_SET_CONFIG  = 2'b10;
  localparam logic [1:0] REQ_CLEAR_CFG   = 2'b11;

  host_state_t state_r;
  host_state_t nxt_state_s;
  logic [15:0] timer_r;
  logic        acc_r;        // request of the current state accepted by the engine
  logic [1:0]  nxt_retry_s;
  logic [6:0]  nxt_addr_s;
  logic        in_req_s;
  logic        accept_s;
  logic        ok_s;
  logic        fail_s;

  // States that hand a request to the control-transfer engine.
  function automatic logic is_req_state(input host_state_t s);
    logic r;
    case (s)
      H_SET_ADDR, H_GET_DESC, H_SET_CONFIG, H_DECONFIG: r = 1'b1;
      default:                                          r = 1'b0;
    endcase
    return r;
  endfunction

  // Request type presented while in the given state.
  function automatic logic [1:0] req_code(input host_state_t s);
    logic [1:0] code;
    case (s)
      H_SET_ADDR:   code = REQ_SET_ADDRESS;
      H_GET_DESC:   code = REQ_GET_DESC;
      H_SET_CONFIG: code = REQ_SET_CONFIG;
      H_DECONFIG:   code = REQ_CLEAR_CFG;
      default:      code = 2'b00;
    endcase
    return code;
  endfunction

  // Request payload presented while in the given state.
  function automatic logic [7:0] req_payload(input host_state_t s);
    logic [7:0] data;
    case (s)
      H_SET_ADDR:   data = {1'b0, DEV_ADDR};
      H_SET_CONFIG: data = CONFIG_VAL;
      default:      data = 8'h00;
    endcase
    return data;
  endfunction

  assign state    = state_r;
  assign accept_s = req_valid & req_ready;
  assign in_req_s = is_req_state(state_r);
  // A response only counts once the request has been accepted in an earlier cycle.
  assign ok_s     = in_req_s & acc_r & rsp_valid & rsp_ok;
  // An OK response in the timeout cycle still wins over the timeout.
  assign fail_s   = in_req_s & ~ok_s &
                    ((acc_r & rsp_valid & ~rsp_ok) | (timer_r == TIMEOUT_LAST));

  // Next-state, retry count and device address from the sampled inputs
  always_comb begin
    nxt_state_s = state_r;
    nxt_retry_s = retry_cnt;
    nxt_addr_s  = dev_addr;
    if (!enable) begin
      nxt_state_s = H_OFF;
      nxt_retry_s = 2'd0;
      nxt_addr_s  = 7'd0;
    end else if (!connect && (state_r != H_OFF)) begin
      nxt_state_s = H_DISCONNECTED;
      nxt_retry_s = 2'd0;
      nxt_addr_s  = 7'd0;
    end else if (fail_s) begin
      if (retry_cnt < RETRY_LIMIT) begin
        nxt_state_s = H_RESET;
        nxt_retry_s = retry_cnt + 2'd1;
        nxt_addr_s  = 7'd0;
      end else begin
        nxt_state_s = H_ERROR;
      end
    end else begin
      case (state_r)
        H_OFF: begin
          nxt_state_s = H_DISCONNECTED;
          nxt_retry_s = 2'd0;
          nxt_addr_s  = 7'd0;
        end
        H_DISCONNECTED: begin
          // connect is known to be high here
          nxt_state_s = H_RESET;
          nxt_addr_s  = 7'd0;
        end
        H_RESET: begin
          if (timer_r == RESET_LAST) begin
            nxt_state_s = H_RECOVERY;
          end else begin
            nxt_state_s = H_RESET;
          end
        end
        H_RECOVERY: begin
          if (timer_r == RECOVERY_LAST) begin
            nxt_state_s = H_SET_ADDR;
          end else begin
            nxt_state_s = H_RECOVERY;
          end
        end
        H_SET_ADDR: begin
          if (ok_s) begin
            nxt_state_s = H_GET_DESC;
            nxt_addr_s  = DEV_ADDR;
          end else begin
            nxt_state_s = H_SET_ADDR;
          end
        end
        H_GET_DESC: begin
          if (ok_s) begin
            nxt_state_s = H_SET_CONFIG;
          end else begin
            nxt_state_s = H_GET_DESC;
          end
        end
        H_SET_CONFIG: begin
          if (ok_s) begin
            nxt_state_s = H_CONFIGURED;
            nxt_retry_s = 2'd0;
          end else begin
            nxt_state_s = H_SET_CONFIG;
          end
        end
        H_DECONFIG: begin
          if (ok_s) begin
            nxt_state_s = H_ADDRESSED;
          end else begin
            nxt_state_s = H_DECONFIG;
          end
        end
        H_CONFIGURED: begin
          if (host_reset) begin
            nxt_state_s = H_RESET;
            nxt_retry_s = 2'd0;
            nxt_addr_s  = 7'd0;
          end else if (deconfigure) begin
            nxt_state_s = H_DECONFIG;
          end else begin
            nxt_state_s = H_CONFIGURED;
          end
        end
        H_ADDRESSED: begin
          if (host_reset) begin
            nxt_state_s = H_RESET;
            nxt_addr_s  = 7'd0;
          end else if (!deconfigure) begin
            nxt_state_s = H_SET_CONFIG;
          end else begin
            nxt_state_s = H_ADDRESSED;
          end
        end
        H_ERROR: begin
          if (host_reset) begin
            nxt_state_s = H_RESET;
            nxt_retry_s = 2'd0;
            nxt_addr_s  = 7'd0;
          end else begin
            nxt_state_s = H_ERROR;
          end
        end
        default: begin
          nxt_state_s = H_OFF;
          nxt_retry_s = 2'd0;
          nxt_addr_s  = 7'd0;
        end
      endcase
    end
  end

  // State, phase timer, handshake tracking and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= H_OFF;
      timer_r    <= 16'd0;
      acc_r      <= 1'b0;
      retry_cnt  <= 2'd0;
      dev_addr   <= 7'd0;
      port_reset <= 1'b0;
      req_valid  <= 1'b0;
      req_type   <= 2'b00;
      req_data   <= 8'h00;
      configured <= 1'b0;
      enum_error <= 1'b0;
    end else begin
      state_r    <= nxt_state_s;
      retry_cnt  <= nxt_retry_s;
      dev_addr   <= nxt_addr_s;
      port_reset <= (nxt_state_s == H_RESET);
      configured <= (nxt_state_s == H_CONFIGURED);
      enum_error <= (nxt_state_s == H_ERROR);
      req_type   <= req_code(nxt_state_s);
      req_data   <= req_payload(nxt_state_s);
      if (nxt_state_s != state_r) begin
        // fresh state: new request (if any) is offered immediately
        timer_r   <= 16'd0;
        acc_r     <= 1'b0;
        req_valid <= is_req_state(nxt_state_s);
      end else begin
        timer_r   <= timer_r + 16'd1;
        acc_r     <= acc_r | accept_s;
        req_valid <= req_valid & ~accept_s;
      end
    end
  end

`ifdef DBC_HOST_ENUM_CNT_EN
  // Count completed configurations, saturating at 255; only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enum_count <= 8'd0;
    end else if ((state_r == H_SET_CONFIG) && (nxt_state_s == H_CONFIGURED) &&
                 (enum_count != 8'hFF)) begin
      enum_count <= enum_count + 8'd1;
    end else begin
      enum_count <= enum_count;
    end
  end
`else
  // Default build: no configuration counter and no enum_count port.
`endif

endmodule
